// File: rtl/pu_stream.sv
// ---------------------------------------------------------------------------
// pu_stream -- streaming FP32 neuron processing unit.
//
// Each accepted beat carries N_IN activation/weight pairs. The lane products
// are summed by a pairwise adder tree and accumulated across the beats of a
// frame; the beat flagged in_last closes the frame and emits one activated
// FP32 result through a valid/ready output port.
//
// Pipeline: S1 lane products -> S2 tree sum -> S3 accumulate / output reg.
// The whole pipeline advances on en = !out_valid || out_ready, so a stalled
// output freezes every stage and no beat is lost or duplicated.
//
// Arithmetic: IEEE-754 single precision, round-to-nearest-even, subnormal
// inputs and results flushed to signed zero.
//
// Configuration macro:
//   PU_RELU_EN  defined   -> activation is ReLU (sign bit set => +0.0)
//               undefined -> activation is identity (bit-exact sum)
//
// Parameters:
//   N_IN   number of multiply lanes (power of two, >= 2)
//   CNT_W  width of the delivered-result counter
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   a_flat     N_IN packed FP32 activations, lane i at [32*i+31:32*i]
//   w_flat     N_IN packed FP32 weights, same packing
//   in_valid   input beat valid
//   in_last    input beat closes the current frame
//   in_ready   block accepts a beat this cycle
//   out_data   FP32 neuron result
//   out_valid  out_data valid
//   out_ready  consumer accepts out_data
//   out_count  number of delivered results, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module pu_stream #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [32*N_IN-1:0]  a_flat,
    input  logic [32*N_IN-1:0]  w_flat,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    out_count
);

    // Round a normalised 27-bit significand (hidden bit at [26], guard at
    // [2], round at [1], sticky at [0]) to nearest-even and pack it.
    // Exponent overflow saturates to infinity, underflow flushes to zero.
    function automatic logic [31:0] round_pack(input logic sign,
                                               input logic signed [9:0] exp_in,
                                               input logic [26:0] man);
        logic               up;
        logic [24:0]        rnd;
        logic [22:0]        frac;
        logic signed [9:0]  e;
        logic [31:0]        r;
        e    = exp_in;
        up   = man[2] & (man[1] | man[0] | man[3]);
        rnd  = {1'b0, man[26:3]} + {24'd0, up};
        // A carry out of rounding leaves 1.000..., so the fraction is zero.
        frac = rnd[24] ? rnd[23:1] : rnd[22:0];
        if (rnd[24]) begin
            e = e + 10'sd1;
        end
        if (e >= 10'sd255) begin
            r = {sign, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            r = {sign, 31'd0};
        end else begin
            r = {sign, e[7:0], frac};
        end
        return r;
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               sign;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0]        p;
        logic [26:0]        m;
        logic signed [9:0]  e;
        logic [31:0]        r;
        sign   = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            m = {p[47:22], |p[21:0]};
            e = e + 10'sd1;
        end else begin
            m = {p[46:21], |p[20:0]};
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            r = 32'h7FC00000;
        end else if (a_inf || b_inf) begin
            r = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            r = {sign, 31'd0};
        end else begin
            r = round_pack(sign, e, m);
        end
        return r;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y, r;
        logic [7:0]         d;
        logic [53:0]        sh;
        logic [26:0]        mx, my, m;
        logic [27:0]        s;
        logic signed [9:0]  e;
        // x is the operand of larger magnitude; it fixes the result sign.
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        sh = {1'b1, y[22:0], 3'b000, 27'd0} >> d;
        my = sh[53:27] | {26'd0, |sh[26:0]};
        if (d > 8'd26) begin
            my = 27'd1;
        end
        if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
        end else begin
            s = {1'b0, mx} - {1'b0, my};
        end
        e = $signed({2'b00, x[30:23]});
        m = s[26:0];
        if (s[27]) begin
            m = {s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!m[26]) begin
                    m = m << 1;
                    e = e - 10'sd1;
                end
            end
        end
        if (x[30:23] == 8'hFF) begin
            // Inf - Inf and NaN operands give the default quiet NaN.
            if ((x[22:0] != 23'd0) || ((y[30:0] == x[30:0]) && (x[31] != y[31])))
                r = 32'h7FC00000;
            else
                r = x;
        end else if ((x[30:23] == 8'd0) && (y[30:23] == 8'd0)) begin
            r = {x[31] & y[31], 31'd0};
        end else if (y[30:23] == 8'd0) begin
            r = x;
        end else if (s == 28'd0) begin
            r = 32'h00000000;
        end else begin
            r = round_pack(x[31], e, m);
        end
        return r;
    endfunction

    // Heap-ordered pairwise tree: leaves at N_IN..2*N_IN-1, root at 1,
    // giving log2(N_IN) adder levels.
    function automatic logic [31:0] tree_sum(input logic [32*N_IN-1:0] p);
        logic [31:0] node [1:2*N_IN-1];
        for (int i = 0; i < N_IN; i++) begin
            node[N_IN+i] = p[32*i +: 32];
        end
        for (int i = N_IN - 1; i >= 1; i--) begin
            node[i] = fp_add(node[2*i], node[2*i+1]);
        end
        return node[1];
    endfunction

    function automatic logic [31:0] activate(input logic [31:0] v);
`ifdef PU_RELU_EN
        return v[31] ? 32'h00000000 : v;
`else
        return v;
`endif
    endfunction

    logic                en;
    logic [32*N_IN-1:0]  prod_c;
    logic [32*N_IN-1:0]  prod_p1;
    logic                vld_p1, last_p1;
    logic [31:0]         sum_p2;
    logic                vld_p2, last_p2;
    logic [31:0]         acc;
    logic [31:0]         acc_sum;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        prod_c = '0;
        for (int i = 0; i < N_IN; i++) begin
            prod_c[32*i +: 32] = fp_mul(a_flat[32*i +: 32], w_flat[32*i +: 32]);
        end
    end

    // ---- S1: lane products ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (en) begin
            vld_p1  <= in_valid;
            last_p1 <= in_valid & in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            prod_p1 <= prod_c;
        end
    end

    // ---- S2: adder tree ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else if (en) begin
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (en && vld_p1) begin
            sum_p2 <= tree_sum(prod_p1);
        end
    end

    // ---- S3: frame accumulation and output register ----
    assign acc_sum = fp_add(acc, sum_p2);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= 32'h00000000;
            out_data  <= 32'h00000000;
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            if (en) begin
                // en=1 means the old result (if any) leaves on this edge.
                out_valid <= vld_p2 & last_p2;
                if (vld_p2) begin
                    if (last_p2) begin
                        acc      <= 32'h00000000;
                        out_data <= activate(acc_sum);
                    end else begin
                        acc <= acc_sum;
                    end
                end
            end
            if (out_valid && out_ready) begin
                out_count <= out_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_pu_stream.sv
// ---------------------------------------------------------------------------
// tb_pu_stream -- self-checking bench for pu_stream (N_IN=4, CNT_W=4).
// Expected results come from real-valued arithmetic on lane values chosen
// as multiples of 0.25 in [-2,2], which FP32 represents exactly, so the
// reference sums convert to the bit-exact FP32 result.
// ---------------------------------------------------------------------------
module tb_pu_stream;
    localparam int N  = 4;
    localparam int CW = 4;

    logic              clk;
    logic              rst;
    logic [32*N-1:0]   a_flat;
    logic [32*N-1:0]   w_flat;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_count;

    int n_tests = 0;
    int n_fail  = 0;

    pu_stream #(.N_IN(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_flat    (a_flat),
        .w_flat    (w_flat),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] real2fp(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h00000000;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic real act(input real r);
`ifdef PU_RELU_EN
        return (r < 0.0) ? 0.0 : r;
`else
        return r;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_const(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < N; i++) begin
            a_flat[32*i +: 32] = a;
            w_flat[32*i +: 32] = w;
        end
    endtask

    task automatic set_random(output real psum);
        int  ka, kw;
        real ra, rw;
        psum = 0.0;
        for (int i = 0; i < N; i++) begin
            ka = int'($urandom_range(16, 0)) - 8;
            kw = int'($urandom_range(16, 0)) - 8;
            ra = ka * 0.25;
            rw = kw * 0.25;
            a_flat[32*i +: 32] = real2fp(ra);
            w_flat[32*i +: 32] = real2fp(rw);
            psum = psum + ra * rw;
        end
    endtask

    // Presents one beat and returns just after the edge that accepts it.
    task automatic send_beat(input bit last);
        int guard = 0;
        in_valid = 1'b1; in_last = last;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Waits (bounded) for out_valid; ok reports whether it was seen.
    task automatic wait_out(output bit ok);
        int guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        ok = out_valid;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL out_timeout: out_valid=%0b, required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        set_const(32'h3F800000, 32'h40000000);
        rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h, required 00000000", out_data); end
        n_tests++; if (out_count !== 4'h0) begin n_fail++; $display("FAIL rst_out_count: got %h, required 0", out_count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b, required 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard: cycle %0d out_valid=%0b, required 0", c, out_valid); end
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        out_ready = 1'b1;
        set_const(32'h3F800000, 32'h40000000);
        send_beat(1'b1);
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: cycle %0d out_valid=%0b, required 0", c, out_valid); end
            @(posedge clk); #1;
        end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: out_valid=%0b, required 1", out_valid); end
        n_tests++; if (out_data !== 32'h41000000) begin n_fail++; $display("FAIL single_data: got %h, required 41000000", out_data); end
        @(posedge clk); #1;
        n_tests++; if (out_count !== 4'h1) begin n_fail++; $display("FAIL single_count: got %h, required 1", out_count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: out_valid=%0b, required 0", out_valid); end
    endtask

    task automatic test_two_beat();
        int pulses = 0;
        do_reset();
        out_ready = 1'b1;
        set_const(32'h3F800000, 32'h40000000);
        send_beat(1'b0);
        set_const(32'h3F800000, 32'h3F000000);
        send_beat(1'b1);
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                pulses++;
                n_tests++;
                if (out_data !== 32'h41200000) begin n_fail++; $display("FAIL two_beat_data: got %h, required 41200000", out_data); end
            end
            @(posedge clk); #1;
        end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL two_beat_count: got %0d results, required 1", pulses); end
    endtask

    task automatic test_negative();
        bit ok;
        logic [31:0] expv;
`ifdef PU_RELU_EN
        expv = 32'h00000000;
`else
        expv = 32'hC0800000;
`endif
        do_reset();
        out_ready = 1'b1;
        set_const(32'h3F800000, 32'hBF800000);
        send_beat(1'b1);
        wait_out(ok);
        if (ok) begin
            n_tests++;
            if (out_data !== expv) begin n_fail++; $display("FAIL negative_data: got %h, required %h", out_data, expv); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] expv [3];
        int idx = 0;
        expv[0] = 32'h40800000; expv[1] = 32'h41000000; expv[2] = 32'h41400000;
        do_reset();
        out_ready = 1'b0;
        set_const(32'h3F800000, 32'h3F800000); send_beat(1'b1);
        set_const(32'h3F800000, 32'h40000000); send_beat(1'b1);
        set_const(32'h3F800000, 32'h40400000); send_beat(1'b1);
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== expv[0]) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d valid=%0b in_ready=%0b data=%h, required 1/0/%h",
                         c, out_valid, in_ready, out_data, expv[0]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && idx < 3) begin
                n_tests++;
                if (out_data !== expv[idx]) begin n_fail++; $display("FAIL bp_order: result %0d got %h, required %h", idx, out_data, expv[idx]); end
                idx++;
            end
            @(posedge clk); #1;
        end
        n_tests++; if (idx != 3) begin n_fail++; $display("FAIL bp_results: got %0d, required 3", idx); end
        n_tests++; if (out_count !== 4'h3) begin n_fail++; $display("FAIL bp_count: got %h, required 3", out_count); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        set_const(32'h3F800000, 32'h40000000);
        send_beat(1'b0);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        out_ready = 1'b1;
        set_const(32'h3F800000, 32'h3F000000);
        send_beat(1'b1);
        wait_out(ok);
        if (ok) begin
            n_tests++;
            if (out_data !== 32'h40000000) begin n_fail++; $display("FAIL midreset_data: got %h, required 40000000", out_data); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        localparam int NB = 8;
        logic [31:0] expv [NB];
        real ps;
        bit  exp_v;
        do_reset();
        out_ready = 1'b1;
        for (int j = 0; j < NB + 5; j++) begin
            exp_v = (j >= 3) && (j < NB + 3);
            n_tests++;
            if (out_valid !== exp_v) begin
                n_fail++; $display("FAIL b2b_valid: cycle %0d got %0b, required %0b", j, out_valid, exp_v);
            end else if (exp_v && out_data !== expv[j-3]) begin
                n_fail++; $display("FAIL b2b_data: result %0d got %h, required %h", j - 3, out_data, expv[j-3]);
            end
            if (j < NB) begin
                set_random(ps);
                expv[j] = real2fp(act(ps));
                in_valid = 1'b1; in_last = 1'b1;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_tests++; if (out_count !== 4'(NB)) begin n_fail++; $display("FAIL b2b_count: got %h, required %h", out_count, 4'(NB)); end
    endtask

    task automatic test_random_stream();
        logic [31:0]   q [$];
        logic [31:0]   held;
        logic [CW-1:0] exp_cnt = '0;
        real  facc = 0.0, cur_ps = 0.0;
        bit   cur_last = 1'b0, holding = 1'b0, delivered, accepted;
        do_reset();
        for (int it = 0; it < 420; it++) begin
            if (!in_valid) begin
                if (it < 380 && $urandom_range(3, 0) != 0) begin
                    set_random(cur_ps);
                    cur_last = ($urandom_range(2, 0) == 0);
                    in_valid = 1'b1; in_last = cur_last;
                end
            end
            out_ready = (it >= 380) || ($urandom_range(3, 0) != 0);
            #1;
            if (holding) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    n_fail++; $display("FAIL rand_hold: valid=%0b data=%h, required 1/%h", out_valid, out_data, held);
                end
            end
            if (out_valid) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra: unexpected result %h, required none", out_data);
                end else if (out_data !== q[0]) begin
                    n_fail++; $display("FAIL rand_data: got %h, required %h", out_data, q[0]);
                end
            end
            delivered = out_valid && out_ready;
            accepted  = in_valid && in_ready;
            holding   = out_valid && !out_ready;
            held      = out_data;
            @(posedge clk); #1;
            if (delivered) begin
                if (q.size() != 0) void'(q.pop_front());
                exp_cnt = exp_cnt + 1'b1;
            end
            if (accepted) begin
                facc = facc + cur_ps;
                if (cur_last) begin
                    q.push_back(real2fp(act(facc)));
                    facc = 0.0;
                end
                in_valid = 1'b0; in_last = 1'b0;
            end
        end
        n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_lost: %0d results missing, required 0", q.size()); end
        n_tests++; if (out_count !== exp_cnt) begin n_fail++; $display("FAIL rand_count: got %h, required %h", out_count, exp_cnt); end
    endtask

    task automatic test_count_wrap();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        set_const(32'h3F800000, 32'h40000000);
        for (int f = 1; f <= 17; f++) begin
            send_beat(1'b1);
            wait_out(ok);
            @(posedge clk); #1;
            if (f == 15) begin
                n_tests++; if (out_count !== 4'hF) begin n_fail++; $display("FAIL wrap_15: got %h, required f", out_count); end
            end else if (f == 16) begin
                n_tests++; if (out_count !== 4'h0) begin n_fail++; $display("FAIL wrap_16: got %h, required 0", out_count); end
            end else if (f == 17) begin
                n_tests++; if (out_count !== 4'h1) begin n_fail++; $display("FAIL wrap_17: got %h, required 1", out_count); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        a_flat = '0; w_flat = '0;
        test_reset();
        test_single_beat();
        test_two_beat();
        test_negative();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_stream();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
